// File: rtl/joystick_input_conditioner_pkg.sv
// ----------------------------------------------------------------------------
// joystick_input_conditioner_pkg : repeat FSM states and default timing
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package joystick_input_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RPT   = 2'd2
  } rpt_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEF_REPEAT_DELAY    = 25_000_000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 5_000_000;

  localparam int NUM_CH   = 2;
  localparam int CH_LEFT  = 0;
  localparam int CH_RIGHT = 1;

endpackage

`default_nettype wire

// File: rtl/joystick_input_conditioner_debounce.sv
// ----------------------------------------------------------------------------
// joy_debounce : polarity normalise, 2-FF synchroniser, stable-count debounce
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module joy_debounce
  import joystick_input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit          RAW_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic deb_o
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             pressed;
  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign pressed = RAW_ACTIVE_LOW ? ~raw_i : raw_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pressed;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any cycle of agreement restarts the stability count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign deb_o = deb_q;

endmodule

`default_nettype wire

// File: rtl/joystick_input_conditioner.sv
// ----------------------------------------------------------------------------
// joystick_input_conditioner : debounced joystick levels plus auto-repeat steps
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module joystick_input_conditioner
  import joystick_input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit          RAW_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic joy_left_raw,
  input  logic joy_right_raw,
  output logic joystick_left,
  output logic joystick_right,
  output logic step_left,
  output logic step_right
);

  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX);
  localparam logic [RPT_W-1:0] DELAY_LOAD  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LOAD = RPT_W'(REPEAT_PERIOD - 1);

  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] deb;
  logic [NUM_CH-1:0] act;
  logic [NUM_CH-1:0] step;

  assign raw = {joy_right_raw, joy_left_raw};

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_deb
      joy_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RAW_ACTIVE_LOW  (RAW_ACTIVE_LOW)
      ) u_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .raw_i (raw[i]),
        .deb_o (deb[i])
      );
    end
  endgenerate

  // Both sides held is ambiguous: neither channel is allowed to step.
  assign act[CH_LEFT]  = deb[CH_LEFT]  & ~deb[CH_RIGHT];
  assign act[CH_RIGHT] = deb[CH_RIGHT] & ~deb[CH_LEFT];

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_rpt
      rpt_state_e       state_q, state_d;
      logic [RPT_W-1:0] rpt_q, rpt_d;
      logic             step_q, step_d;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= ST_IDLE;
          rpt_q   <= '0;
          step_q  <= 1'b0;
        end else begin
          state_q <= state_d;
          rpt_q   <= rpt_d;
          step_q  <= step_d;
        end
      end

      always_comb begin
        state_d = state_q;
        rpt_d   = rpt_q;
        step_d  = 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (act[i]) begin
              step_d  = 1'b1;
              rpt_d   = DELAY_LOAD;
              state_d = ST_DELAY;
            end
          end
          ST_DELAY: begin
            if (!act[i]) begin
              state_d = ST_IDLE;
            end else if (rpt_q == '0) begin
              step_d  = 1'b1;
              rpt_d   = PERIOD_LOAD;
              state_d = ST_RPT;
            end else begin
              rpt_d = rpt_q - 1'b1;
            end
          end
          ST_RPT: begin
            if (!act[i]) begin
              state_d = ST_IDLE;
            end else if (rpt_q == '0) begin
              step_d = 1'b1;
              rpt_d  = PERIOD_LOAD;
            end else begin
              rpt_d = rpt_q - 1'b1;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end

      assign step[i] = step_q;
    end
  endgenerate

  assign joystick_left  = deb[CH_LEFT];
  assign joystick_right = deb[CH_RIGHT];
  assign step_left      = step[CH_LEFT];
  assign step_right     = step[CH_RIGHT];

endmodule

`default_nettype wire

// File: tb/tb_joystick_input_conditioner.sv
// ----------------------------------------------------------------------------
// tb_joystick_input_conditioner : directed self-checking bench
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_joystick_input_conditioner;

  logic clk    = 1'b0;
  logic rst_n  = 1'b1;
  logic jl_raw = 1'b1;
  logic jr_raw = 1'b1;
  logic jl, jr, sl, sr;

  int checks   = 0;
  int failures = 0;

  joystick_input_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (5),
    .RAW_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .joy_left_raw   (jl_raw),
    .joy_right_raw  (jr_raw),
    .joystick_left  (jl),
    .joystick_right (jr),
    .step_left      (sl),
    .step_right     (sr)
  );

  always #5 clk = ~clk;

  // Positions the bench 1 ns after a rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_all();
    jl_raw = 1'b1;
    jr_raw = 1'b1;
    repeat (14) tick();
    checks++;
    if ({jl, jr, sl, sr} !== 4'b0000) begin
      failures++;
      $display("FAIL release_idle outs{jl,jr,sl,sr}=%b exp=0000", {jl, jr, sl, sr});
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({jl, jr, sl, sr} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_async outs{jl,jr,sl,sr}=%b exp=0000", {jl, jr, sl, sr});
    end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (8) tick();
    checks++;
    if ({jl, jr, sl, sr} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_idle outs{jl,jr,sl,sr}=%b exp=0000", {jl, jr, sl, sr});
    end
  endtask

  task automatic test_press();
    logic [3:0] exp;
    jl_raw = 1'b0;
    for (int t = 1; t <= 9; t++) begin
      tick();
      exp = {(t >= 6), 1'b0, (t == 7), 1'b0};
      checks++;
      if ({jl, jr, sl, sr} !== exp) begin
        failures++;
        $display("FAIL press t=%0d outs{jl,jr,sl,sr}=%b exp=%b", t, {jl, jr, sl, sr}, exp);
      end
    end
    release_all();
  endtask

  task automatic test_glitch();
    int hi = 0;
    jl_raw = 1'b0;
    for (int t = 1; t <= 15; t++) begin
      tick();
      if (t == 3) jl_raw = 1'b1;
      if (jl || sl) hi++;
    end
    checks++;
    if (hi != 0) begin
      failures++;
      $display("FAIL glitch cycles_with_jl_or_sl=%0d exp=0", hi);
    end
  endtask

  task automatic test_hold();
    int pl[$];
    int pr = 0;
    int exp_l[7] = '{7, 17, 22, 27, 32, 37, 42};
    logic jl45 = 1'b0;
    logic jl46 = 1'b1;
    jl_raw = 1'b0;
    for (int t = 1; t <= 55; t++) begin
      tick();
      if (sl) pl.push_back(t);
      if (sr) pr++;
      if (t == 45) jl45 = jl;
      if (t == 46) jl46 = jl;
      if (t == 40) jl_raw = 1'b1;
    end
    checks++;
    if (pl.size() != 7) begin
      failures++;
      $display("FAIL hold_step_count got=%0d exp=7", pl.size());
    end
    for (int i = 0; i < 7 && i < pl.size(); i++) begin
      checks++;
      if (pl[i] != exp_l[i]) begin
        failures++;
        $display("FAIL hold_step_time idx=%0d got=%0d exp=%0d", i, pl[i], exp_l[i]);
      end
    end
    checks++;
    if (pr != 0) begin
      failures++;
      $display("FAIL hold_right_steps got=%0d exp=0", pr);
    end
    checks++;
    if ({jl45, jl46} !== 2'b10) begin
      failures++;
      $display("FAIL hold_release_latency jl@45,46=%b exp=10", {jl45, jl46});
    end
    release_all();
  endtask

  task automatic test_both();
    int pl[$];
    int pr[$];
    int exp_r[3] = '{37, 47, 52};
    logic [1:0] lv30 = 2'b00;
    logic [1:0] jl3536 = 2'b00;
    jl_raw = 1'b0;
    for (int t = 1; t <= 55; t++) begin
      tick();
      if (sl) pl.push_back(t);
      if (sr) pr.push_back(t);
      if (t == 30) lv30 = {jl, jr};
      if (t == 35) jl3536[1] = jl;
      if (t == 36) jl3536[0] = jl;
      if (t == 10) jr_raw = 1'b0;
      if (t == 30) jl_raw = 1'b1;
    end
    checks++;
    if (lv30 !== 2'b11) begin
      failures++;
      $display("FAIL both_levels {jl,jr}=%b exp=11", lv30);
    end
    checks++;
    if (pl.size() != 1 || pl[0] != 7) begin
      failures++;
      $display("FAIL both_left_steps count=%0d first=%0d exp count=1 first=7",
               pl.size(), (pl.size() > 0) ? pl[0] : -1);
    end
    checks++;
    if (jl3536 !== 2'b10) begin
      failures++;
      $display("FAIL both_left_release jl@35,36=%b exp=10", jl3536);
    end
    checks++;
    if (pr.size() != 3) begin
      failures++;
      $display("FAIL both_right_count got=%0d exp=3", pr.size());
    end
    for (int i = 0; i < 3 && i < pr.size(); i++) begin
      checks++;
      if (pr[i] != exp_r[i]) begin
        failures++;
        $display("FAIL both_right_time idx=%0d got=%0d exp=%0d", i, pr[i], exp_r[i]);
      end
    end
    release_all();
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp;
    jl_raw = 1'b0;
    repeat (25) tick();
    checks++;
    if (jl !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre jl=%b exp=1", jl);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({jl, jr, sl, sr} !== 4'b0000) begin
      failures++;
      $display("FAIL rstmid_async outs{jl,jr,sl,sr}=%b exp=0000", {jl, jr, sl, sr});
    end
    repeat (3) tick();
    rst_n = 1'b1;
    for (int t = 1; t <= 9; t++) begin
      tick();
      exp = {(t >= 6), 1'b0, (t == 7), 1'b0};
      checks++;
      if ({jl, jr, sl, sr} !== exp) begin
        failures++;
        $display("FAIL rstmid_recover t=%0d outs{jl,jr,sl,sr}=%b exp=%b", t, {jl, jr, sl, sr}, exp);
      end
    end
    release_all();
  endtask

  task automatic test_bounce();
    int   rises  = 0;
    int   rise_s = -1;
    int   steps  = 0;
    int   step_s = -1;
    logic prev   = 1'b0;
    for (int t = 0; t < 36; t++) begin
      if (t < 20 && (t % 2) == 0) jl_raw = ((t / 2) % 2 == 1);
      else if (t == 20)           jl_raw = 1'b0;
      tick();
      if (jl && !prev) begin
        rises++;
        rise_s = t + 1;
      end
      if (sl) begin
        steps++;
        step_s = t + 1;
      end
      prev = jl;
    end
    checks++;
    if (rises != 1 || rise_s != 26) begin
      failures++;
      $display("FAIL bounce_rise count=%0d at=%0d exp count=1 at=26", rises, rise_s);
    end
    checks++;
    if (steps != 1 || step_s != 27) begin
      failures++;
      $display("FAIL bounce_step count=%0d at=%0d exp count=1 at=27", steps, step_s);
    end
    release_all();
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_hold();
    test_both();
    test_reset_mid();
    test_bounce();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
